// File: rtl/reg_file_wb_arbiter.sv
// reg_file_wb_arbiter: round-robin arbiter for the reg_file write port, with a load scoreboard and a decode stall.
// Ports:
//   clk, rst                  clock and synchronous active-low reset
//   alu_valid/ready/addr/data ALU writeback requester
//   ld_valid/ready/addr/data  load-return writeback requester
//   rsv_valid, rsv_addr       reserve a destination register for an issued load
//   rs1_addr, rs2_addr        decode-stage sources checked for hazards
//   stall_o                   decode hold on a read-after-write hazard
//   RegWrite/WriteAddr/WriteData  registered reg_file write port
//   pending                   scoreboard, bit i set while a load to xi is outstanding
module reg_file_wb_arbiter #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter int NREGS  = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              alu_valid,
   output logic              alu_ready,
   input  logic [ADDR_W-1:0] alu_addr,
   input  logic [DATA_W-1:0] alu_data,
   input  logic              ld_valid,
   output logic              ld_ready,
   input  logic [ADDR_W-1:0] ld_addr,
   input  logic [DATA_W-1:0] ld_data,
   input  logic              rsv_valid,
   input  logic [ADDR_W-1:0] rsv_addr,
   input  logic [ADDR_W-1:0] rs1_addr,
   input  logic [ADDR_W-1:0] rs2_addr,
   output logic              stall_o,
   output logic              RegWrite,
   output logic [ADDR_W-1:0] WriteAddr,
   output logic [DATA_W-1:0] WriteData,
   output logic [NREGS-1:0]  pending
);
   logic              ptr_q, ptr_d;
   logic              wr_q, wr_d;
   logic [ADDR_W-1:0] waddr_q, waddr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [NREGS-1:0]  pend_q, pend_d;
   logic              alu_elig, alu_gnt, ld_gnt, haz1, haz2;
   // ptr_q=1 favours the load path; an ALU write to a register with an outstanding load is held back (WAW)
   assign alu_elig  = alu_valid && !pend_q[alu_addr];
   assign ld_gnt    = ld_valid && (!alu_elig || ptr_q);
   assign alu_gnt   = alu_elig && (!ld_valid || !ptr_q);
   // no handshake may complete while reset is asserted
   assign alu_ready = alu_gnt && rst;
   assign ld_ready  = ld_gnt && rst;
   always_comb begin
      ptr_d   = (alu_gnt || ld_gnt) ? alu_gnt : ptr_q;
      wr_d    = (alu_gnt && alu_addr != '0) || (ld_gnt && ld_addr != '0);
      waddr_d = !wr_d ? waddr_q : ld_gnt ? ld_addr : alu_addr;
      wdata_d = !wr_d ? wdata_q : ld_gnt ? ld_data : alu_data;
      pend_d  = pend_q;
      if (ld_gnt) pend_d[ld_addr] = 1'b0;
      if (rsv_valid) pend_d[rsv_addr] = 1'b1;
      pend_d[0] = 1'b0;
   end
   always_ff @(posedge clk) begin
      if (!rst) begin
         ptr_q   <= 1'b1;
         wr_q    <= 1'b0;
         waddr_q <= '0;
         wdata_q <= '0;
         pend_q  <= '0;
      end else begin
         ptr_q   <= ptr_d;
         wr_q    <= wr_d;
         waddr_q <= waddr_d;
         wdata_q <= wdata_d;
         pend_q  <= pend_d;
      end
   end
   // a source is hazardous while its load is outstanding or its write sits in the output stage
   assign haz1      = rs1_addr != '0 && (pend_q[rs1_addr] || (wr_q && waddr_q == rs1_addr));
   assign haz2      = rs2_addr != '0 && (pend_q[rs2_addr] || (wr_q && waddr_q == rs2_addr));
   assign stall_o   = haz1 || haz2;
   assign RegWrite  = wr_q;
   assign WriteAddr = waddr_q;
   assign WriteData = wdata_q;
   assign pending   = pend_q;
endmodule

// File: tb/tb_reg_file_wb_arbiter.sv
// tb_reg_file_wb_arbiter: directed self-checking bench for reg_file_wb_arbiter.
module tb_reg_file_wb_arbiter;
   logic        clk = 1'b0;
   logic        rst;
   logic        alu_valid, alu_ready, ld_valid, ld_ready, rsv_valid, stall_o, RegWrite;
   logic [4:0]  alu_addr, ld_addr, rsv_addr, rs1_addr, rs2_addr, WriteAddr;
   logic [31:0] alu_data, ld_data, WriteData, pending;
   int          total = 0;
   int          bad = 0;

   reg_file_wb_arbiter dut (
      .clk(clk), .rst(rst),
      .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_addr(alu_addr), .alu_data(alu_data),
      .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr), .ld_data(ld_data),
      .rsv_valid(rsv_valid), .rsv_addr(rsv_addr), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
      .stall_o(stall_o), .RegWrite(RegWrite), .WriteAddr(WriteAddr), .WriteData(WriteData),
      .pending(pending)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   initial begin
      rst = 1'b0;
      alu_valid = 1'b1; alu_addr = 5'd5; alu_data = 32'ha000b000;
      ld_valid = 1'b0; ld_addr = '0; ld_data = '0;
      rsv_valid = 1'b0; rsv_addr = '0; rs1_addr = '0; rs2_addr = '0;
      tick();
      tick();
      chk("rst_regwrite", {31'd0, RegWrite}, 32'd0);
      chk("rst_pending", pending, 32'd0);
      chk("rst_waddr", {27'd0, WriteAddr}, 32'd0);
      chk("rst_alu_ready", {31'd0, alu_ready}, 32'd0);
      rst = 1'b1; rs1_addr = 5'd5;
      #1;
      chk("post_rst_alu_ready", {31'd0, alu_ready}, 32'd1);
      tick();
      alu_valid = 1'b0;
      #1;
      chk("alu_regwrite", {31'd0, RegWrite}, 32'd1);
      chk("alu_waddr", {27'd0, WriteAddr}, 32'd5);
      chk("alu_wdata", WriteData, 32'ha000b000);
      chk("alu_stall", {31'd0, stall_o}, 32'd1);
      tick();
      chk("alu_idle_regwrite", {31'd0, RegWrite}, 32'd0);
      chk("alu_idle_stall", {31'd0, stall_o}, 32'd0);
      chk("alu_idle_wdata_hold", WriteData, 32'ha000b000);

      // both requesters valid: ld favoured after the ALU grant, then alternation
      alu_valid = 1'b1; alu_addr = 5'd1; alu_data = 32'h11111111;
      ld_valid = 1'b1; ld_addr = 5'd2; ld_data = 32'h22222222; rs1_addr = '0;
      #1;
      chk("rr0_ld_ready", {31'd0, ld_ready}, 32'd1);
      chk("rr0_alu_ready", {31'd0, alu_ready}, 32'd0);
      tick();
      chk("rr1_waddr", {27'd0, WriteAddr}, 32'd2);
      chk("rr1_wdata", WriteData, 32'h22222222);
      chk("rr1_alu_ready", {31'd0, alu_ready}, 32'd1);
      chk("rr1_ld_ready", {31'd0, ld_ready}, 32'd0);
      tick();
      chk("rr2_waddr", {27'd0, WriteAddr}, 32'd1);
      chk("rr2_wdata", WriteData, 32'h11111111);
      chk("rr2_ld_ready", {31'd0, ld_ready}, 32'd1);
      tick();
      chk("rr3_waddr", {27'd0, WriteAddr}, 32'd2);
      chk("rr3_alu_ready", {31'd0, alu_ready}, 32'd1);
      tick();
      alu_valid = 1'b0; ld_valid = 1'b0;
      chk("rr4_waddr", {27'd0, WriteAddr}, 32'd1);
      chk("rr4_regwrite", {31'd0, RegWrite}, 32'd1);

      // x0 write is accepted but suppressed
      tick();
      alu_valid = 1'b1; alu_addr = 5'd0; alu_data = 32'hffffffff;
      #1;
      chk("x0_alu_ready", {31'd0, alu_ready}, 32'd1);
      tick();
      alu_valid = 1'b0;
      #1;
      chk("x0_regwrite", {31'd0, RegWrite}, 32'd0);
      chk("x0_stall", {31'd0, stall_o}, 32'd0);
      chk("x0_pending", pending, 32'd0);

      // scoreboard reserve, WAW block, load clear
      rsv_valid = 1'b1; rsv_addr = 5'd7;
      tick();
      rsv_valid = 1'b0; rs2_addr = 5'd7;
      alu_valid = 1'b1; alu_addr = 5'd7; alu_data = 32'h77777777;
      #1;
      chk("sb_pending_set", pending, 32'h00000080);
      chk("sb_stall", {31'd0, stall_o}, 32'd1);
      chk("sb_alu_blocked", {31'd0, alu_ready}, 32'd0);
      tick();
      chk("sb_alu_still_blocked", {31'd0, alu_ready}, 32'd0);
      chk("sb_no_write", {31'd0, RegWrite}, 32'd0);
      ld_valid = 1'b1; ld_addr = 5'd7; ld_data = 32'h12345678;
      #1;
      chk("sb_ld_ready", {31'd0, ld_ready}, 32'd1);
      chk("sb_ld_alu_ready", {31'd0, alu_ready}, 32'd0);
      tick();
      ld_valid = 1'b0;
      #1;
      chk("sb_pending_clr", pending, 32'd0);
      chk("sb_ld_regwrite", {31'd0, RegWrite}, 32'd1);
      chk("sb_ld_waddr", {27'd0, WriteAddr}, 32'd7);
      chk("sb_ld_wdata", WriteData, 32'h12345678);
      chk("sb_ld_stall", {31'd0, stall_o}, 32'd1);
      chk("sb_alu_accepted", {31'd0, alu_ready}, 32'd1);
      tick();
      alu_valid = 1'b0;
      chk("sb_alu_wdata", WriteData, 32'h77777777);
      chk("sb_alu_waddr", {27'd0, WriteAddr}, 32'd7);
      tick();
      chk("sb_final_stall", {31'd0, stall_o}, 32'd0);
      chk("sb_final_regwrite", {31'd0, RegWrite}, 32'd0);
      rs2_addr = '0;

      // simultaneous set and clear of x3: set wins
      rsv_valid = 1'b1; rsv_addr = 5'd3;
      ld_valid = 1'b1; ld_addr = 5'd3; ld_data = 32'h33333333;
      #1;
      chk("sc_ld_ready", {31'd0, ld_ready}, 32'd1);
      tick();
      rsv_valid = 1'b0; ld_valid = 1'b0;
      #1;
      chk("sc_pending", pending, 32'h00000008);
      chk("sc_waddr", {27'd0, WriteAddr}, 32'd3);
      chk("sc_regwrite", {31'd0, RegWrite}, 32'd1);

      // reset mid-sequence with a live ALU request
      alu_valid = 1'b1; alu_addr = 5'd4; alu_data = 32'h44444444; rst = 1'b0;
      #1;
      chk("mrst_alu_ready", {31'd0, alu_ready}, 32'd0);
      tick();
      rst = 1'b1; alu_valid = 1'b0;
      chk("mrst_pending", pending, 32'd0);
      chk("mrst_regwrite", {31'd0, RegWrite}, 32'd0);
      tick();
      chk("mrst_no_write", {31'd0, RegWrite}, 32'd0);
      // pointer back to load side after reset
      alu_valid = 1'b1; alu_addr = 5'd1; ld_valid = 1'b1; ld_addr = 5'd2;
      #1;
      chk("mrst_ptr_ld", {31'd0, ld_ready}, 32'd1);
      chk("mrst_ptr_alu", {31'd0, alu_ready}, 32'd0);
      alu_valid = 1'b0; ld_valid = 1'b0;
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
